// File: rtl/ow_slave.sv
// 1-Wire slave bit engine: reset/presence detection, write-slot
// sampling and read-slot driving for a byte-wide personality layer.
module ow_slave #(
  parameter int US_CYCLES    = 50,
  parameter int RST_US       = 480,
  parameter int PRES_WAIT_US = 30,
  parameter int PRES_US      = 120,
  parameter int SAMPLE_US    = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dq_in,
  output logic       dq_oe,
  output logic       bus_reset,
  output logic       online,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_busy
);

  localparam int PW = (US_CYCLES > 1) ? $clog2(US_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SLOT,
    LOW,
    PRES_WAIT,
    PRES_DRIVE,
    REL
  } state_t;

  state_t        state;
  logic          dq_m;
  logic          dq_s;
  logic          dq_d;
  logic          fall;
  logic [PW-1:0] pre;
  logic [9:0]    us_cnt;
  logic          tick;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx_sh;
  logic [7:0]    tx_sh;
  logic          rst_hit;
  logic          load_ok;

  assign fall = dq_d & ~dq_s;
  assign tick = (pre == PW'(US_CYCLES - 1));

  // a low long enough to be a bus reset, seen at its rising edge
  assign rst_hit = (state == LOW) && dq_s &&
                   (us_cnt >= 10'(RST_US));

  assign load_ok = tx_load && !tx_busy && online &&
                   !bus_reset && !rst_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dq_m <= 1'b1;
      dq_s <= 1'b1;
      dq_d <= 1'b1;
    end else begin
      dq_m <= dq_in;
      dq_s <= dq_m;
      dq_d <= dq_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pre       <= '0;
      us_cnt    <= '0;
      dq_oe     <= 1'b0;
      bus_reset <= 1'b0;
      online    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_busy   <= 1'b0;
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
    end else begin
      bus_reset <= 1'b0;
      rx_valid  <= 1'b0;

      if (tick) begin
        pre <= '0;
        if (us_cnt != 10'h3ff)
          us_cnt <= us_cnt + 10'd1;
      end else begin
        pre <= pre + PW'(1);
      end

      unique case (state)
        IDLE: begin
          if (fall) begin
            pre    <= '0;
            us_cnt <= '0;
            if (online) begin
              state <= SLOT;
              dq_oe <= tx_busy & ~tx_sh[0];
            end else begin
              state <= LOW;
            end
          end
        end

        // timer keeps running into LOW so the reset check
        // measures the whole low time from the falling edge
        SLOT: begin
          if (us_cnt == 10'(SAMPLE_US)) begin
            rx_sh   <= {dq_s, rx_sh[7:1]};
            tx_sh   <= {1'b0, tx_sh[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            dq_oe   <= 1'b0;
            state   <= LOW;
            if (bit_cnt == 3'd7) begin
              if (tx_busy) begin
                tx_busy <= 1'b0;
              end else begin
                rx_data  <= {dq_s, rx_sh[7:1]};
                rx_valid <= 1'b1;
              end
            end
          end
        end

        LOW: begin
          if (dq_s) begin
            pre    <= '0;
            us_cnt <= '0;
            if (rst_hit) begin
              bus_reset <= 1'b1;
              bit_cnt   <= '0;
              rx_sh     <= '0;
              tx_sh     <= '0;
              tx_busy   <= 1'b0;
              state     <= PRES_WAIT;
            end else begin
              state <= IDLE;
            end
          end
        end

        PRES_WAIT: begin
          if (us_cnt == 10'(PRES_WAIT_US)) begin
            pre    <= '0;
            us_cnt <= '0;
            dq_oe  <= 1'b1;
            state  <= PRES_DRIVE;
          end
        end

        PRES_DRIVE: begin
          if (tick && us_cnt == 10'(PRES_US - 1)) begin
            pre    <= '0;
            us_cnt <= '0;
            dq_oe  <= 1'b0;
            online <= 1'b1;
            state  <= REL;
          end
        end

        REL: begin
          if (dq_s) begin
            pre    <= '0;
            us_cnt <= '0;
            state  <= IDLE;
          end
        end

        default: begin
          dq_oe <= 1'b0;
          state <= IDLE;
        end
      endcase

      if (load_ok) begin
        tx_sh   <= tx_data;
        bit_cnt <= '0;
        tx_busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ow_slave.sv
// Directed bench for ow_slave: a master model pulls DQ low and the
// slave's pull-down is wired-ANDed onto the same line.
module tb_ow_slave;

  localparam int U = 5;

  logic       clk;
  logic       reset;
  logic       dq_in;
  logic       dq_oe;
  logic       bus_reset;
  logic       online;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_busy;
  logic       mlow;

  int n_cmp;
  int n_err;
  int idx;
  int br_cnt;
  int br_first;
  int rv_cnt;
  int oe_cycles;
  int oe_first;

  ow_slave #(
    .US_CYCLES(U)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .dq_in    (dq_in),
    .dq_oe    (dq_oe),
    .bus_reset(bus_reset),
    .online   (online),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_busy  (tx_busy)
  );

  assign dq_in = ~(mlow | dq_oe);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    idx       = 0;
    br_cnt    = 0;
    br_first  = -1;
    rv_cnt    = 0;
    oe_cycles = 0;
    oe_first  = -1;
  endtask

  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idx++;
      if (bus_reset) begin
        br_cnt++;
        if (br_first < 0) br_first = idx;
      end
      if (rx_valid) rv_cnt++;
      if (dq_oe) begin
        oe_cycles++;
        if (oe_first < 0) oe_first = idx;
      end
    end
  endtask

  task automatic wr_slot(input logic b);
    mlow = 1'b1;
    watch(b ? 6 * U : 60 * U);
    mlow = 1'b0;
    watch(b ? 64 * U : 10 * U);
  endtask

  task automatic rd_slot(output logic r);
    mlow = 1'b1;
    watch(6 * U);
    mlow = 1'b0;
    watch(7 * U);
    r = dq_in;
    watch(57 * U);
  endtask

  task automatic long_low(input int us);
    mlow = 1'b1;
    watch(us * U);
    @(negedge clk);
    mlow = 1'b0;
  endtask

  logic [7:0] wbyte;
  logic       rbit;
  logic [7:0] exp_tx;
  logic       found;

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b1;
    mlow    = 1'b0;
    tx_load = 1'b0;
    tx_data = 8'h00;
    clear_stats();
    repeat (3) @(negedge clk);
    check("rst_dq_oe", dq_oe, 0);
    check("rst_bus_reset", bus_reset, 0);
    check("rst_online", online, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_busy", tx_busy, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // offline: slots ignored, load refused
    clear_stats();
    wbyte = 8'h5A;
    for (int i = 0; i < 8; i++) wr_slot(wbyte[i]);
    check("off_oe", oe_cycles, 0);
    check("off_rv", rv_cnt, 0);
    check("off_online", online, 0);
    tx_data = 8'h3C;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    @(negedge clk);
    check("off_tx_busy", tx_busy, 0);

    // first bus reset and presence
    long_low(500);
    clear_stats();
    watch(800);
    check("br1_cnt", br_cnt, 1);
    check("br1_lat", br_first, 3);
    check("pres1_start", (oe_first >= 152 && oe_first <= 156), 1);
    check("pres1_len", oe_cycles, 6 * 100);
    check("online1", online, 1);

    // write 0xA5
    clear_stats();
    wbyte = 8'hA5;
    for (int i = 0; i < 8; i++) wr_slot(wbyte[i]);
    check("wr_rv_cnt", rv_cnt, 1);
    check("wr_rx_data", rx_data, 8'hA5);
    check("wr_oe", oe_cycles, 0);

    // transmit 0x3C; second load while busy must be ignored
    tx_data = 8'h3C;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    check("tx_busy_set", tx_busy, 1);
    tx_data = 8'hFF;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    clear_stats();
    exp_tx = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      rd_slot(rbit);
      check($sformatf("rd_bit%0d", i), rbit, exp_tx[i]);
      if (i == 6) check("tx_busy_b7", tx_busy, 1);
    end
    check("tx_busy_end", tx_busy, 0);
    check("rd_rv_cnt", rv_cnt, 0);

    // 300 us low while online: bit 0, no reset
    clear_stats();
    long_low(300);
    watch(10 * U);
    check("short_br", br_cnt, 0);
    for (int i = 0; i < 7; i++) wr_slot(1'b1);
    check("short_rv", rv_cnt, 1);
    check("short_rx", rx_data, 8'hFE);

    // online bus reset with a colliding tx_load
    long_low(500);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus_reset) found = 1'b1;
    end
    check("br2_seen", found, 1);
    tx_data = 8'h00;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    check("br2_load_drop", tx_busy, 0);
    check("br2_rx_keep", rx_data, 8'hFE);

    // async reset in the middle of presence
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (dq_oe) found = 1'b1;
    end
    check("pres2_seen", found, 1);
    repeat (50) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("async_oe", dq_oe, 0);
    @(negedge clk);
    check("ar_online", online, 0);
    check("ar_rx_data", rx_data, 8'h00);
    check("ar_tx_busy", tx_busy, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // normal reset/presence after the async reset
    long_low(500);
    clear_stats();
    watch(800);
    check("br3_cnt", br_cnt, 1);
    check("pres3_start", (oe_first >= 152 && oe_first <= 156), 1);
    check("pres3_len", oe_cycles, 6 * 100);
    check("online3", online, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
